// File: rtl/dc_stage_reg.sv
// D-cache tag-to-memory stage pipeline register. The cache status bits are merged into
// the status field of the bus, and a saturating counter records stall cycles.
module dc_stage_reg #(
  parameter int BUS_WD     = 275,
  parameter int STATUS_POS = 150,
  parameter int STATUS_WD  = 3,
  parameter int STALL_WD   = 7,
  parameter int STALL_IDX  = 5,
  parameter int STICKY     = 1,
  parameter int CNT_WD     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [STALL_WD-1:0]  stall,
  input  logic [STATUS_WD-1:0] status_in,
  input  logic                 perf_clr,
  input  logic [BUS_WD-1:0]    in_bus,
  output logic [BUS_WD-1:0]    out_bus,
  output logic [CNT_WD-1:0]    stall_cnt
);

  localparam logic [CNT_WD-1:0] CNT_MAX = {CNT_WD{1'b1}};
  localparam logic [CNT_WD-1:0] CNT_ONE = {{(CNT_WD-1){1'b0}}, 1'b1};

  logic                 s_s;
  logic                 d_s;
  logic                 unused_stall_s;
  logic [STATUS_WD-1:0] acc_s;
  logic [STATUS_WD-1:0] eff_s;
  logic [BUS_WD-1:0]    nxt_bus_s;
  logic [BUS_WD-1:0]    out_bus_r;
  logic [CNT_WD-1:0]    stall_cnt_r;

  assign s_s            = stall[STALL_IDX];
  assign d_s            = stall[STALL_IDX+1];
  assign unused_stall_s = ^stall;

  generate
    if (STICKY != 0) begin : g_sticky
      logic [STATUS_WD-1:0] acc_r;

      // Collect status pulses seen while stalled; the advance edge consumes them.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_r <= {STATUS_WD{1'b0}};
        end else if (flush) begin
          acc_r <= {STATUS_WD{1'b0}};
        end else if (!s_s) begin
          acc_r <= {STATUS_WD{1'b0}};
        end else begin
          acc_r <= acc_r | status_in;
        end
      end

      assign acc_s = acc_r;
    end else begin : g_plain
      assign acc_s = {STATUS_WD{1'b0}};
    end
  endgenerate

  // Next bus value on advance: the incoming bus with its status field overwritten.
  always_comb begin
    eff_s     = status_in | acc_s;
    nxt_bus_s = in_bus;
    nxt_bus_s[STATUS_POS +: STATUS_WD] = eff_s;
  end

  // Stage register: flushes and bubbles insert zeros, and a downstream stall holds the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bus_r <= {BUS_WD{1'b0}};
    end else if (flush) begin
      out_bus_r <= {BUS_WD{1'b0}};
    end else if (s_s && !d_s) begin
      out_bus_r <= {BUS_WD{1'b0}};
    end else if (!s_s) begin
      out_bus_r <= nxt_bus_s;
    end else begin
      out_bus_r <= out_bus_r;
    end
  end

  // Saturating stall-cycle counter; a clear takes precedence over counting.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_cnt_r <= {CNT_WD{1'b0}};
    end else if (s_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign out_bus   = out_bus_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dc_stage_reg.sv
// Scoreboard bench for dc_stage_reg: sticky, non-sticky and 4-bit-counter instances
// share the same stimulus, and a monitor checks the queued expectations every cycle.
module tb_dc_stage_reg;

  localparam int BW = 275;
  localparam int SP = 150;

  localparam logic [6:0] ADV  = 7'b0011111;
  localparam logic [6:0] HOLD = 7'b1110101;
  localparam logic [6:0] BUB  = 7'b0101010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          perf_clr = 1'b0;
  logic [6:0]    stall = 7'b0;
  logic [2:0]    status_in = 3'b0;
  logic [BW-1:0] in_bus = '0;

  logic [BW-1:0] ob0, ob1, ob2;
  logic [15:0]   sc0, sc1;
  logic [3:0]    sc2;

  always #5 clk = ~clk;

  dc_stage_reg #(.STICKY(1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .status_in(status_in),
    .perf_clr(perf_clr), .in_bus(in_bus), .out_bus(ob0), .stall_cnt(sc0));

  dc_stage_reg #(.STICKY(0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .status_in(status_in),
    .perf_clr(perf_clr), .in_bus(in_bus), .out_bus(ob1), .stall_cnt(sc1));

  dc_stage_reg #(.STICKY(1), .CNT_WD(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .status_in(status_in),
    .perf_clr(perf_clr), .in_bus(in_bus), .out_bus(ob2), .stall_cnt(sc2));

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int            tgt;
    logic [1:0]    dut;
    logic          cb;
    logic [BW-1:0] bus;
    logic          cc;
    logic [15:0]   cnt;
  } exp_t;

  exp_t  q[$];
  string nq[$];

  function automatic logic [BW-1:0] mk(input logic [BW-1:0] b, input logic [2:0] f);
    logic [BW-1:0] r;
    r = b;
    r[SP +: 3] = f;
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] r;
    for (int i = 0; i < BW; i++) r[i] = 1'($urandom_range(1, 0));
    return r;
  endfunction

  task automatic drive(input logic r, input logic f, input logic [6:0] st,
                       input logic [2:0] sts, input logic pc, input logic [BW-1:0] ib);
    @(negedge clk);
    #1;
    rst = r; flush = f; stall = st; status_in = sts; perf_clr = pc; in_bus = ib;
  endtask

  task automatic push(input int dut, input logic cb, input logic [BW-1:0] b,
                      input logic cc, input logic [15:0] c, input string nm);
    exp_t e;
    e.tgt = cyc + 1; e.dut = 2'(dut); e.cb = cb; e.bus = b; e.cc = cc; e.cnt = c;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  // Monitor: compare every expectation due after the edge that just happened.
  initial begin
    exp_t          e;
    string         nm;
    logic [BW-1:0] ab;
    logic [15:0]   ac;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tgt <= cyc) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        case (e.dut)
          2'd0:    begin ab = ob0; ac = sc0; end
          2'd1:    begin ab = ob1; ac = sc1; end
          default: begin ab = ob2; ac = {12'b0, sc2}; end
        endcase
        if (e.cb) begin
          n_cmp++;
          if (ab !== e.bus) begin
            n_bad++;
            $display("FAIL %s dut%0d out_bus: got %h want %h", nm, e.dut, ab, e.bus);
          end
        end
        if (e.cc) begin
          n_cmp++;
          if (ac !== e.cnt) begin
            n_bad++;
            $display("FAIL %s dut%0d stall_cnt: got %0d want %0d", nm, e.dut, ac, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] ones, p, qv, a1, z;
    int            budget;
    ones = '1;
    p    = {55{5'b10110}};
    qv   = {25{11'b01101001110}};
    z    = '0;
    a1   = mk(ones, 3'b101);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), rnd_bus());
      for (int d = 0; d < 3; d++) push(d, 1'b1, z, 1'b1, 16'd0, "reset");
    end
    drive(1'b0, 1'b0, ADV, 3'b101, 1'b0, ones);
    push(0, 1'b1, a1, 1'b1, 16'd0, "first_adv");
    push(1, 1'b1, a1, 1'b1, 16'd0, "first_adv");

    // Sticky accumulation over a hold
    drive(1'b0, 1'b0, HOLD, 3'b001, 1'b0, p);
    push(0, 1'b1, a1, 1'b1, 16'd1, "hold1");
    push(1, 1'b1, a1, 1'b1, 16'd1, "hold1");
    drive(1'b0, 1'b0, HOLD, 3'b100, 1'b0, p);
    push(0, 1'b1, a1, 1'b1, 16'd2, "hold2");
    drive(1'b0, 1'b0, HOLD, 3'b000, 1'b0, p);
    push(0, 1'b1, a1, 1'b1, 16'd3, "hold3");
    drive(1'b0, 1'b0, ADV, 3'b000, 1'b0, p);
    push(0, 1'b1, mk(p, 3'b101), 1'b1, 16'd3, "sticky_adv");
    push(1, 1'b1, mk(p, 3'b000), 1'b1, 16'd3, "nosticky_adv");
    drive(1'b0, 1'b0, ADV, 3'b000, 1'b0, qv);
    push(0, 1'b1, mk(qv, 3'b000), 1'b0, 16'd0, "sticky_cleared");
    push(1, 1'b1, mk(qv, 3'b000), 1'b0, 16'd0, "nosticky_adv2");

    // Bubble
    drive(1'b0, 1'b0, BUB, 3'b010, 1'b0, p);
    for (int d = 0; d < 3; d++) push(d, 1'b1, z, 1'b1, 16'd4, "bubble");
    drive(1'b0, 1'b0, ADV, 3'b000, 1'b0, qv);
    push(0, 1'b1, mk(qv, 3'b010), 1'b1, 16'd4, "after_bubble");
    push(1, 1'b1, mk(qv, 3'b000), 1'b0, 16'd0, "after_bubble");

    // Flush discards the accumulated status, counter untouched
    drive(1'b0, 1'b0, HOLD, 3'b111, 1'b0, p);
    push(0, 1'b1, mk(qv, 3'b010), 1'b1, 16'd5, "hold_pre_flush");
    drive(1'b0, 1'b1, ADV, 3'b000, 1'b0, p);
    for (int d = 0; d < 3; d++) push(d, 1'b1, z, 1'b1, 16'd5, "flush_adv");
    drive(1'b0, 1'b0, ADV, 3'b000, 1'b0, qv);
    push(0, 1'b1, mk(qv, 3'b000), 1'b1, 16'd5, "post_flush");
    push(1, 1'b1, mk(qv, 3'b000), 1'b0, 16'd0, "post_flush");

    // Accumulated and same-cycle status merge on advance
    drive(1'b0, 1'b0, HOLD, 3'b001, 1'b0, p);
    push(0, 1'b1, mk(qv, 3'b000), 1'b1, 16'd6, "hold_merge");
    drive(1'b0, 1'b0, ADV, 3'b100, 1'b0, qv);
    push(0, 1'b1, mk(qv, 3'b101), 1'b1, 16'd6, "merge_adv");
    push(1, 1'b1, mk(qv, 3'b100), 1'b0, 16'd0, "merge_adv");

    // Reset mid-stall drops pending status
    drive(1'b0, 1'b0, HOLD, 3'b011, 1'b0, p);
    push(0, 1'b0, z, 1'b1, 16'd7, "hold_pre_rst");
    drive(1'b1, 1'b0, HOLD, 3'b000, 1'b0, p);
    for (int d = 0; d < 3; d++) push(d, 1'b1, z, 1'b1, 16'd0, "rst_mid_stall");
    drive(1'b0, 1'b0, ADV, 3'b000, 1'b0, p);
    push(0, 1'b1, mk(p, 3'b000), 1'b1, 16'd0, "post_rst_adv");

    // Counter saturation and clear
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, HOLD, 3'b000, 1'b0, p);
      push(0, 1'b0, z, 1'b1, 16'(i + 1), "cnt16");
      push(2, 1'b0, z, 1'b1, (i + 1 > 15) ? 16'd15 : 16'(i + 1), "cnt4_sat");
    end
    push(0, 1'b1, mk(p, 3'b000), 1'b0, 16'd0, "hold_long");
    drive(1'b0, 1'b0, HOLD, 3'b000, 1'b1, p);
    push(0, 1'b0, z, 1'b1, 16'd0, "perf_clr");
    push(2, 1'b0, z, 1'b1, 16'd0, "perf_clr");
    drive(1'b0, 1'b0, HOLD, 3'b000, 1'b0, p);
    push(0, 1'b0, z, 1'b1, 16'd1, "after_clr");
    push(2, 1'b0, z, 1'b1, 16'd1, "after_clr");

    drive(1'b0, 1'b0, ADV, 3'b000, 1'b0, p);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
